serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/sa_fa_bit.sv | 23 ++
 rtl/serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sa_fa_bit.sv
// One-bit full adder built from two half-add stages and an OR.
module sa_fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    logic h1_s;
    logic h1_c;
    logic h2_c;

    // First half-add on the operand bits, second on the partial sum and carry-in
    always_comb begin
        h1_s = a_i ^ b_i;
        h1_c = a_i & b_i;
        s_o  = h1_s ^ c_i;
        h2_c = h1_s & c_i;
        co_o = h1_c | h2_c;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: accepts an operand pair, adds one bit per cycle LSB first,
// then holds the result under valid/ready backpressure.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             BUSY
);

    localparam int unsigned   CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cnt_inc;
    logic             fa_s;
    logic             fa_co;
    logic             accept;

    sa_fa_bit u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // Handshake and status outputs decoded from the current state
    always_comb begin
        IN_READY  = (state_q == IDLE) || ((state_q == DONE) && OUT_READY);
        OUT_VALID = (state_q == DONE);
        BUSY      = (state_q == SHIFT);
        SUM       = sum_q;
        COUT      = carry_q;
        accept    = IN_VALID && IN_READY;
    end

    // Ripple incrementer for the bit counter, kept gate-level so the block has no adder operator
    always_comb begin
        logic ripple;
        cnt_inc = '0;
        ripple  = 1'b1;
        for (int unsigned i = 0; i < CW; i++) begin
            cnt_inc[i] = cnt_q[i] ^ ripple;
            ripple     = ripple & cnt_q[i];
        end
    end

    // Next-state and datapath: load on accept, one full-add per SHIFT cycle, hold in DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            SHIFT: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_inc;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OUT_READY && !IN_VALID) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        // Accept overrides the per-state behaviour in IDLE and in DONE (retire + reload)
        if (accept) begin
            a_d     = A;
            b_d     = B;
            carry_d = CIN;
            cnt_d   = '0;
            state_d = SHIFT;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with a result scoreboard.
module tb_serial_add_ctrl;

    typedef struct packed {
        logic       cout;
        logic [7:0] sum;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] A;
    logic [7:0] B;
    logic       CIN;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] SUM;
    logic       COUT;
    logic       BUSY;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    serial_add_ctrl #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .CIN       (CIN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .SUM       (SUM),
        .COUT      (COUT),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] tot;
        tot = {1'b0, a} + {1'b0, b} + {8'd0, c};
        return exp_t'(tot);
    endfunction

    // One complete operation from IDLE: accept, latency/BUSY count, result, optional hold, release.
    task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic c, input int hold, input bit toggle);
        exp_t e;
        int   lat;
        int   busy_n;
        A         = a;
        B         = b;
        CIN       = c;
        IN_VALID  = 1'b1;
        OUT_READY = 1'b0;
        #1;
        chk({tag, "_in_ready"}, 64'(IN_READY), 64'd1);
        sb.push_back(model(a, b, c));
        step();
        IN_VALID = 1'b0;
        chk({tag, "_busy_after_accept"}, 64'(BUSY), 64'd1);
        lat    = 0;
        busy_n = 0;
        while (!OUT_VALID && lat < 40) begin
            busy_n += int'(BUSY);
            if (toggle) begin
                A         = 8'($urandom);
                B         = 8'($urandom);
                CIN       = 1'($urandom);
                IN_VALID  = 1'($urandom);
                OUT_READY = 1'($urandom);
            end
            step();
            lat++;
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'd8);
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd8);
        chk({tag, "_busy_in_done"}, 64'(BUSY), 64'd0);
        e = sb.pop_front();
        chk({tag, "_sum"}, 64'(SUM), 64'(e.sum));
        chk({tag, "_cout"}, 64'(COUT), 64'(e.cout));
        repeat (hold) begin
            step();
            chk({tag, "_hold_sum"}, 64'(SUM), 64'(e.sum));
            chk({tag, "_hold_cout"}, 64'(COUT), 64'(e.cout));
            chk({tag, "_hold_valid"}, 64'(OUT_VALID), 64'd1);
            chk({tag, "_hold_in_ready"}, 64'(IN_READY), 64'd0);
        end
        OUT_READY = 1'b1;
        #1;
        chk({tag, "_in_ready_release"}, 64'(IN_READY), 64'd1);
        step();
        chk({tag, "_valid_cleared"}, 64'(OUT_VALID), 64'd0);
        chk({tag, "_idle_busy"}, 64'(BUSY), 64'd0);
        OUT_READY = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   cyc;
        int   pulses;
        int   first;
        int   gap;
        int   ov_seen;

        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        A         = '0;
        B         = '0;
        CIN       = 1'b0;

        // Reset state
        step();
        chk("rst_in_ready", 64'(IN_READY), 64'd1);
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_sum", 64'(SUM), 64'd0);
        chk("rst_cout", 64'(COUT), 64'd0);
        step();
        RST = 1'b0;

        // First accept on the first edge after release, then basic vectors
        run_one("v5a_33", 8'h5A, 8'h33, 1'b0, 0, 1'b0);
        run_one("vff_01", 8'hFF, 8'h01, 1'b0, 0, 1'b0);
        run_one("vff_ff_c", 8'hFF, 8'hFF, 1'b1, 0, 1'b0);

        // Backpressure held for 5 cycles
        run_one("hold5", 8'hC3, 8'h7E, 1'b1, 5, 1'b0);

        // Back-to-back pairs with both handshakes held high
        A         = 8'h01;
        B         = 8'h02;
        CIN       = 1'b0;
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        sb.push_back(model(8'h01, 8'h02, 1'b0));
        sb.push_back(model(8'h10, 8'h20, 1'b0));
        step();
        A      = 8'h10;
        B      = 8'h20;
        cyc    = 0;
        pulses = 0;
        first  = 0;
        gap    = 0;
        while (pulses < 2 && cyc < 40) begin
            step();
            cyc++;
            if (pulses == 1 && cyc == first + 1) IN_VALID = 1'b0;
            if (OUT_VALID) begin
                pulses++;
                if (pulses == 1) first = cyc;
                else gap = cyc - first;
                e = sb.pop_front();
                chk("b2b_sum", 64'(SUM), 64'(e.sum));
                chk("b2b_cout", 64'(COUT), 64'(e.cout));
            end
        end
        IN_VALID = 1'b0;
        chk("b2b_pulses", 64'(pulses), 64'd2);
        chk("b2b_first_latency", 64'(first), 64'd8);
        chk("b2b_gap", 64'(gap), 64'd9);
        step();
        chk("b2b_idle_valid", 64'(OUT_VALID), 64'd0);
        chk("b2b_idle_busy", 64'(BUSY), 64'd0);
        OUT_READY = 1'b0;

        // Reset in the middle of SHIFT discards the operation
        A        = 8'hAA;
        B        = 8'h55;
        CIN      = 1'b1;
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        repeat (4) step();
        chk("mid_busy", 64'(BUSY), 64'd1);
        #1;
        RST = 1'b1;
        #1;
        chk("mid_rst_sum", 64'(SUM), 64'd0);
        chk("mid_rst_cout", 64'(COUT), 64'd0);
        chk("mid_rst_valid", 64'(OUT_VALID), 64'd0);
        chk("mid_rst_busy", 64'(BUSY), 64'd0);
        chk("mid_rst_in_ready", 64'(IN_READY), 64'd1);
        step();
        #2;
        RST     = 1'b0;
        ov_seen = 0;
        repeat (12) begin
            step();
            ov_seen += int'(OUT_VALID);
            ov_seen += int'(BUSY);
        end
        chk("post_rst_quiet", 64'(ov_seen), 64'd0);
        run_one("post_rst_0f_01", 8'h0F, 8'h01, 1'b0, 0, 1'b0);

        // Inputs and OUT_READY toggled randomly while shifting
        for (int i = 0; i < 4; i++) begin
            run_one($sformatf("toggle%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), i, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
